// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: start/done handshake, stall hold, LUT branch redirect, halt detect.
// Latency: pc updates one cycle after the retiring instruction; a taken branch adds one FLUSH bubble.
// Backpressure: i_stall holds pc/state/counters in RUN, and is ignored in FLUSH. Optional macro: FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
    parameter int         PC_W    = 32,
    parameter int         STEP    = 4,
    parameter int         LUT_AW  = 4,
    parameter logic [8:0] HALT_OP = 9'h1FF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_start_pc,
    input  logic              i_stall,
    input  logic [8:0]        i_instruction,
    input  logic              i_branch,
    input  logic              i_zero,
    input  logic              i_lut_we,
    input  logic [LUT_AW-1:0] i_lut_waddr,
    input  logic [PC_W-1:0]   i_lut_wdata,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_fetch_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_retired_count,
    output logic [31:0]       o_taken_count
);

    localparam int LUT_D = 1 << LUT_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_fetch_valid;
    logic              r_busy;
    logic              r_done;
    logic [PC_W-1:0]   r_lut [LUT_D];

    logic              w_ctl_idle;
    logic              w_halt;
    logic              w_take;
    logic [PC_W-1:0]   w_target;

    assign w_ctl_idle = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_halt     = (i_instruction == HALT_OP);
    assign w_take     = i_branch && i_zero;
    assign w_target   = r_lut[i_instruction[LUT_AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_fetch_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state       <= S_RUN;
                        r_pc          <= i_start_pc;
                        r_fetch_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!i_stall) begin
                        // Halt wins over a simultaneous branch; pc stays on the halt.
                        if (w_halt) begin
                            r_state       <= S_DONE;
                            r_fetch_valid <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end else if (w_take) begin
                            r_state       <= S_FLUSH;
                            r_pc          <= w_target;
                            r_fetch_valid <= 1'b0;
                        end else begin
                            r_pc <= r_pc + PC_W'(STEP);
                        end
                    end
                end
                S_FLUSH: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_fetch_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    // Target table is only writable while no program is executing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LUT_D; i++) begin
                r_lut[i] <= '0;
            end
        end else if (i_lut_we && w_ctl_idle) begin
            r_lut[i_lut_waddr] <= i_lut_wdata;
        end
    end

    assign o_pc          = r_pc;
    assign o_fetch_valid = r_fetch_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

`ifdef FETCH_SEQ_PERF_EN
    logic        w_retire;
    logic [31:0] r_retired_count;
    logic [31:0] r_taken_count;

    assign w_retire = (r_state == S_RUN) && !i_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_retired_count <= '0;
            r_taken_count   <= '0;
        end else if (w_ctl_idle && i_start) begin
            r_retired_count <= '0;
            r_taken_count   <= '0;
        end else if (w_retire) begin
            if (r_retired_count != 32'hFFFF_FFFF) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
            if (!w_halt && w_take && (r_taken_count != 32'hFFFF_FFFF)) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign o_retired_count = r_retired_count;
    assign o_taken_count   = r_taken_count;
`else
    assign o_retired_count = '0;
    assign o_taken_count   = '0;
`endif

endmodule
